// File: rtl/regfile_scan_arbiter.sv
// CPU register file with a shared read port: the CPU has fixed priority and a display
// scanner uses idle read cycles. Also performs the post-reset initialisation sweep.
module regfile_scan_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int SP_INDEX  = 2,
  parameter int SP_INIT   = 127
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_waddr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  input  logic                 cpu_rreq,
  input  logic [ADDR_W-1:0]    cpu_raddr,
  output logic                 cpu_rvalid,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 init_busy,
  input  logic                 scan_en,
  input  logic                 scan_ready,
  output logic                 scan_valid,
  output logic [ADDR_W-1:0]    scan_addr,
  output logic [WORD_SIZE-1:0] scan_data,
  output logic                 frame_done
);

  localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0]    SP_ADDR  = ADDR_W'(SP_INDEX);
  localparam logic [WORD_SIZE-1:0] SP_VAL   = WORD_SIZE'(SP_INIT);

  typedef enum logic {INIT, RUN} top_state_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_PRESENT} scan_state_t;

  top_state_t  top_state, top_next;
  scan_state_t scan_state, scan_next;

  logic [ADDR_W-1:0]    init_idx;
  logic [ADDR_W-1:0]    scan_idx;
  logic [ADDR_W-1:0]    scan_addr_q;
  logic [WORD_SIZE-1:0] scan_data_q;
  logic                 cpu_rvalid_q;
  logic [WORD_SIZE-1:0] cpu_rdata_q;

  logic [WORD_SIZE-1:0] mem [NUM_REGS];

  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 cpu_grant;
  logic                 scan_grant;
  logic                 scan_accept;
  logic [ADDR_W-1:0]    rd_addr;
  logic [WORD_SIZE-1:0] rd_word;

  // Top FSM: INIT sweeps every register once, then hands the file to the CPU.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    top_next = top_state;
    if (top_state == INIT && init_idx == LAST_IDX) top_next = RUN;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      top_state <= INIT;
      init_idx  <= '0;
    end else begin
      top_state <= top_next;
      if (top_state == INIT) init_idx <= init_idx + 1'b1;
    end
  end

  // Write port: owned by the sweep during INIT, by the CPU afterwards; register 0 is read-only.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cpu_waddr;
    wr_data = cpu_wdata;
    if (!reset) begin
      if (top_state == INIT) begin
        wr_en   = 1'b1;
        wr_addr = init_idx;
        wr_data = (init_idx == SP_ADDR) ? SP_VAL : '0;
      end else begin
        wr_en = cpu_we && (cpu_waddr != '0);
      end
    end
  end

  // NOTE: the array has no reset; the INIT sweep gives it defined contents instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port arbitration and write-first bypass.
  always_comb begin
    cpu_grant  = (top_state == RUN) && cpu_rreq;
    scan_grant = (top_state == RUN) && !cpu_rreq && (scan_state == S_ISSUE);
    rd_addr    = cpu_rreq ? cpu_raddr : scan_idx;
    rd_word    = (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
  end

  // Scanner FSM next state.
  always_comb begin
    scan_next   = scan_state;
    scan_accept = 1'b0;
    unique case (scan_state)
      S_IDLE:    if (scan_en) scan_next = S_ISSUE;
      S_ISSUE:   if (scan_grant) scan_next = S_PRESENT;
      S_PRESENT: begin
        if (scan_ready) begin
          scan_accept = 1'b1;
          scan_next   = scan_en ? S_ISSUE : S_IDLE;
        end
      end
      default:   scan_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_state   <= S_IDLE;
      scan_idx     <= '0;
      scan_addr_q  <= '0;
      scan_data_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      scan_state   <= scan_next;
      cpu_rvalid_q <= cpu_grant;
      if (cpu_grant) cpu_rdata_q <= rd_word;
      if (scan_grant) begin
        scan_addr_q <= scan_idx;
        scan_data_q <= rd_word;
      end else if (scan_state == S_PRESENT && wr_en && wr_addr == scan_addr_q) begin
        // Keep the presented word coherent with CPU writes while it waits for acceptance.
        scan_data_q <= wr_data;
      end
      if (scan_accept) scan_idx <= scan_idx + 1'b1;
    end
  end

  assign init_busy  = (top_state == INIT);
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign scan_valid = (scan_state == S_PRESENT);
  assign scan_addr  = scan_addr_q;
  assign scan_data  = scan_data_q;
  assign frame_done = scan_accept && (scan_addr_q == LAST_IDX);

endmodule

// File: tb/tb_regfile_scan_arbiter.sv
// Directed self-checking bench for regfile_scan_arbiter: init sweep, CPU read/write,
// scanner frame, starvation, coherence and mid-handshake reset.
module tb_regfile_scan_arbiter;

  localparam int WORD_SIZE = 32;
  localparam int ADDR_W    = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cpu_we;
  logic [ADDR_W-1:0]    cpu_waddr;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic                 cpu_rreq;
  logic [ADDR_W-1:0]    cpu_raddr;
  logic                 cpu_rvalid;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 init_busy;
  logic                 scan_en;
  logic                 scan_ready;
  logic                 scan_valid;
  logic [ADDR_W-1:0]    scan_addr;
  logic [WORD_SIZE-1:0] scan_data;
  logic                 frame_done;

  int checks = 0;
  int errors = 0;

  regfile_scan_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_we     (cpu_we),
    .cpu_waddr  (cpu_waddr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rreq   (cpu_rreq),
    .cpu_raddr  (cpu_raddr),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .init_busy  (init_busy),
    .scan_en    (scan_en),
    .scan_ready (scan_ready),
    .scan_valid (scan_valid),
    .scan_addr  (scan_addr),
    .scan_data  (scan_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp, input string tag);
    cpu_rreq  = 1'b1;
    cpu_raddr = addr;
    tick();
    check({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd1);
    check(tag, cpu_rdata, exp);
    cpu_rreq = 1'b0;
  endtask

  function automatic logic [31:0] frame_exp(input int addr);
    case (addr)
      2:       return 32'd127;
      5:       return 32'hDEAD_BEEF;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    int cycles;
    int bad;
    int n;
    int last;
    int fd;
    int gap_bad;

    reset      = 1'b1;
    cpu_we     = 1'b0;
    cpu_waddr  = '0;
    cpu_wdata  = '0;
    cpu_rreq   = 1'b0;
    cpu_raddr  = '0;
    scan_en    = 1'b0;
    scan_ready = 1'b0;
    #1;
    repeat (3) tick();

    check("rst_init_busy",  32'(init_busy),  32'd1);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_cpu_rdata",  cpu_rdata,       32'd0);
    check("rst_scan_valid", 32'(scan_valid), 32'd0);
    check("rst_scan_addr",  32'(scan_addr),  32'd0);
    check("rst_scan_data",  scan_data,       32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // Release reset; CPU traffic during INIT must be ignored.
    reset     = 1'b0;
    cpu_we    = 1'b1;
    cpu_waddr = 5'd3;
    cpu_wdata = 32'h0000_FFFF;
    cpu_rreq  = 1'b1;
    cpu_raddr = 5'd2;
    cycles = 0;
    bad    = 0;
    while (init_busy && cycles < 40) begin
      tick();
      cycles++;
      if (cpu_rvalid) bad++;
    end
    cpu_we   = 1'b0;
    cpu_rreq = 1'b0;
    check("init_cycles", 32'(cycles), 32'd32);
    check("init_no_rvalid", 32'(bad), 32'd0);

    cpu_read(5'd2,  32'd127, "rd_sp");
    cpu_read(5'd0,  32'd0,   "rd_r0");
    cpu_read(5'd1,  32'd0,   "rd_r1");
    cpu_read(5'd31, 32'd0,   "rd_r31");
    cpu_read(5'd3,  32'd0,   "rd_r3_init_write_ignored");

    // Write-first bypass.
    cpu_we    = 1'b1;
    cpu_waddr = 5'd5;
    cpu_wdata = 32'hDEAD_BEEF;
    cpu_read(5'd5, 32'hDEAD_BEEF, "bypass_r5");
    cpu_we = 1'b0;
    cpu_read(5'd5, 32'hDEAD_BEEF, "rd_r5");

    // Register 0 is read-only, with and without a same-cycle read.
    cpu_we    = 1'b1;
    cpu_waddr = 5'd0;
    cpu_wdata = 32'h0000_1234;
    cpu_read(5'd0, 32'd0, "bypass_r0");
    cpu_we = 1'b0;
    cpu_read(5'd0, 32'd0, "rd_r0_after_write");
    tick();
    check("rvalid_pulse", 32'(cpu_rvalid), 32'd0);

    // Full scan frame plus wrap to 0 with no CPU traffic.
    scan_en    = 1'b1;
    scan_ready = 1'b1;
    n = 0; cycles = 0; last = -1; fd = 0; gap_bad = 0;
    while (n < 33 && cycles < 200) begin
      tick();
      cycles++;
      if (frame_done) fd++;
      if (scan_valid) begin
        check($sformatf("scan_addr_%0d", n), 32'(scan_addr), 32'(n % 32));
        if (scan_addr == 5'd2 || scan_addr == 5'd5)
          check($sformatf("scan_data_%0d", n), scan_data, frame_exp(n % 32));
        if (last >= 0 && cycles - last != 2) gap_bad++;
        last = cycles;
        n++;
      end
    end
    check("scan_words", 32'(n), 32'd33);
    check("frame_done_count", 32'(fd), 32'd1);
    check("scan_two_cycle_rate", 32'(gap_bad), 32'd0);

    // Accept word 0, then starve the scanner with 10 CPU reads.
    tick();
    check("issue_after_accept", 32'(scan_valid), 32'd0);
    cpu_rreq  = 1'b1;
    cpu_raddr = 5'd2;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (scan_valid) bad++;
      if (!cpu_rvalid || cpu_rdata != 32'd127) bad++;
    end
    cpu_rreq = 1'b0;
    check("starve_no_scan_valid", 32'(bad), 32'd0);
    tick();
    check("starve_resume_valid", 32'(scan_valid), 32'd1);
    check("starve_resume_addr",  32'(scan_addr),  32'd1);

    // Stall on address 7 and write it from the CPU.
    cycles = 0;
    while (!(scan_valid && scan_addr == 5'd7) && cycles < 60) begin
      tick();
      cycles++;
    end
    scan_ready = 1'b0;
    check("reach_addr7", 32'(scan_valid && scan_addr == 5'd7), 32'd1);
    cpu_we    = 1'b1;
    cpu_waddr = 5'd7;
    cpu_wdata = 32'h0000_0055;
    tick();
    cpu_we = 1'b0;
    check("coh_data",  scan_data,        32'h55);
    check("coh_valid", 32'(scan_valid),  32'd1);
    check("coh_addr",  32'(scan_addr),   32'd7);

    // Drop scan_en mid-handshake: word stays until accepted, then no reissue.
    scan_en = 1'b0;
    tick();
    tick();
    check("hold_valid", 32'(scan_valid), 32'd1);
    check("hold_addr",  32'(scan_addr),  32'd7);
    scan_ready = 1'b1;
    tick();
    check("idle_after_accept", 32'(scan_valid), 32'd0);
    tick();
    tick();
    check("idle_no_reissue", 32'(scan_valid), 32'd0);

    // Reset while presenting address 12.
    scan_en = 1'b1;
    cycles  = 0;
    while (!(scan_valid && scan_addr == 5'd12) && cycles < 60) begin
      tick();
      cycles++;
    end
    scan_ready = 1'b0;
    check("reach_addr12", 32'(scan_valid && scan_addr == 5'd12), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_valid", 32'(scan_valid), 32'd0);
    check("rst_mid_busy",  32'(init_busy),  32'd1);
    scan_ready = 1'b1;
    cycles = 0;
    while (!scan_valid && cycles < 100) begin
      tick();
      cycles++;
    end
    check("reinit_first_valid", 32'(scan_valid), 32'd1);
    check("reinit_first_addr",  32'(scan_addr),  32'd0);
    check("reinit_first_data",  scan_data,       32'd0);
    scan_en = 1'b0;
    cpu_read(5'd7, 32'd0,   "reinit_rd_r7");
    cpu_read(5'd2, 32'd127, "reinit_rd_sp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
